// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer
// Description : Next-state address generator for a microprogrammed control
//               unit. Supports increment, jump, opcode dispatch, conditional
//               branch, wait-on-condition with a timeout watchdog, and a small
//               micro-subroutine call/return stack.
// Revision    : 1.0 - initial release
// ============================================================================
module microsequencer #(
  parameter int unsigned STATE_W      = 10,
  parameter int unsigned STACK_DEPTH  = 4,    // power of two, 2..4 (depth port is 3 bits)
  parameter int unsigned WAIT_TIMEOUT = 255   // 1..65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] current_state,
  input  logic [2:0]         seq_op,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic [STATE_W-1:0] dispatch_addr,
  input  logic [1:0]         cond_sel,
  input  logic               cond_inv,
  input  logic               moc,
  input  logic               cond_flag,
  input  logic               ir_cond,
  output logic [STATE_W-1:0] next_state,
  output logic               stack_err,
  output logic               timeout,
  output logic [2:0]         depth
);

  // Sequencing operation encodings
  localparam logic [2:0] C_OP_INC      = 3'd0;
  localparam logic [2:0] C_OP_JUMP     = 3'd1;
  localparam logic [2:0] C_OP_DISPATCH = 3'd2;
  localparam logic [2:0] C_OP_BRANCH   = 3'd3;
  localparam logic [2:0] C_OP_WAIT     = 3'd4;
  localparam logic [2:0] C_OP_CALL     = 3'd5;
  localparam logic [2:0] C_OP_RET      = 3'd6;
  localparam logic [2:0] C_OP_RESTART  = 3'd7;

  localparam int unsigned C_PTR_W = $clog2(STACK_DEPTH);
  localparam logic [2:0]  C_FULL  = 3'(STACK_DEPTH);
  // Value of the held-cycle counter on the held cycle that trips the watchdog
  localparam logic [15:0] C_WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

  // Registered state
  logic [STATE_W-1:0] r_next_state;
  logic [2:0]         r_depth;
  logic               r_stack_err;
  logic               r_timeout;
  logic [15:0]        r_wait_cnt;
  logic [STATE_W-1:0] r_stack [STACK_DEPTH];

  // Combinational decisions
  logic               w_src;
  logic               w_test;
  logic [STATE_W-1:0] w_incr;
  logic [STATE_W-1:0] w_next;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_set_err;
  logic               w_set_to;
  logic [15:0]        w_wait_nxt;
  logic [C_PTR_W-1:0] w_wr_idx;
  logic [C_PTR_W-1:0] w_rd_idx;
  logic [STATE_W-1:0] w_top;

  // Stack pointers: write slot is the current depth, top is one below it
  assign w_wr_idx = r_depth[C_PTR_W-1:0];
  assign w_rd_idx = w_wr_idx - C_PTR_W'(1);
  assign w_top    = r_stack[w_rd_idx];
  assign w_incr   = current_state + STATE_W'(1);

  // Select and optionally invert the branch/wait test source
  always_comb begin
    w_src = 1'b1;
    case (cond_sel)
      2'd0:    w_src = moc;
      2'd1:    w_src = cond_flag;
      2'd2:    w_src = ir_cond;
      default: w_src = 1'b1;
    endcase
    w_test = w_src ^ cond_inv;
  end

  // Next-state selection, stack control and watchdog decisions
  always_comb begin
    w_next     = w_incr;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_flush    = 1'b0;
    w_set_err  = 1'b0;
    w_set_to   = 1'b0;
    w_wait_nxt = 16'd0;
    case (seq_op)
      C_OP_INC:      w_next = w_incr;
      C_OP_JUMP:     w_next = cr_addr;
      C_OP_DISPATCH: w_next = dispatch_addr;
      C_OP_BRANCH:   w_next = w_test ? cr_addr : w_incr;
      C_OP_WAIT: begin
        if (w_test) begin
          w_next = w_incr;
        end else if (r_wait_cnt == C_WAIT_LAST) begin
          // Watchdog expired: abandon the wait and restart the microprogram
          w_next   = '0;
          w_set_to = 1'b1;
          w_flush  = 1'b1;
        end else begin
          w_next     = current_state;
          w_wait_nxt = r_wait_cnt + 16'd1;
        end
      end
      C_OP_CALL: begin
        // The jump is taken even when the return address cannot be saved
        w_next = cr_addr;
        if (r_depth == C_FULL) begin
          w_set_err = 1'b1;
        end else begin
          w_push = 1'b1;
        end
      end
      C_OP_RET: begin
        if (r_depth == 3'd0) begin
          w_next    = '0;
          w_set_err = 1'b1;
        end else begin
          w_next = w_top;
          w_pop  = 1'b1;
        end
      end
      C_OP_RESTART: begin
        w_next  = '0;
        w_flush = 1'b1;
      end
      default: w_next = w_incr;
    endcase
  end

  // Control registers: next state, occupancy, sticky flags, wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_next_state <= '0;
      r_depth      <= 3'd0;
      r_stack_err  <= 1'b0;
      r_timeout    <= 1'b0;
      r_wait_cnt   <= 16'd0;
    end else begin
      r_next_state <= w_next;
      r_wait_cnt   <= w_wait_nxt;
      if (w_set_err) r_stack_err <= 1'b1;
      if (w_set_to)  r_timeout   <= 1'b1;
      if (w_flush) begin
        r_depth <= 3'd0;
      end else if (w_push) begin
        r_depth <= r_depth + 3'd1;
      end else if (w_pop) begin
        r_depth <= r_depth - 3'd1;
      end
    end
  end

  // Return-address storage; contents are meaningless while depth is zero
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_wr_idx] <= w_incr;
  end

  assign next_state = r_next_state;
  assign stack_err  = r_stack_err;
  assign timeout    = r_timeout;
  assign depth      = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_microsequencer
// Description : Self-checking bench for microsequencer: directed scenarios
//               followed by randomized traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microsequencer;

  localparam int STATE_W = 10;
  localparam int SDEPTH  = 4;
  localparam int WTO     = 4;
  localparam int NSTATES = 1 << STATE_W;

  logic               clk = 1'b0;
  logic               reset;
  logic [STATE_W-1:0] current_state;
  logic [2:0]         seq_op;
  logic [STATE_W-1:0] cr_addr;
  logic [STATE_W-1:0] dispatch_addr;
  logic [1:0]         cond_sel;
  logic               cond_inv;
  logic               moc;
  logic               cond_flag;
  logic               ir_cond;
  logic [STATE_W-1:0] next_state;
  logic               stack_err;
  logic               timeout;
  logic [2:0]         depth;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_stack[$];
  int m_held;
  int m_next;
  bit m_err;
  bit m_to;

  microsequencer #(
    .STATE_W(STATE_W), .STACK_DEPTH(SDEPTH), .WAIT_TIMEOUT(WTO)
  ) dut (
    .clk(clk), .reset(reset), .current_state(current_state), .seq_op(seq_op),
    .cr_addr(cr_addr), .dispatch_addr(dispatch_addr), .cond_sel(cond_sel),
    .cond_inv(cond_inv), .moc(moc), .cond_flag(cond_flag), .ir_cond(ir_cond),
    .next_state(next_state), .stack_err(stack_err), .timeout(timeout),
    .depth(depth)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".next_state"}, 32'(next_state), 32'(m_next));
    chk({tag, ".depth"},      32'(depth),      32'(m_stack.size()));
    chk({tag, ".stack_err"},  32'(stack_err),  32'(m_err));
    chk({tag, ".timeout"},    32'(timeout),    32'(m_to));
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_held = 0;
    m_next = 0;
    m_err  = 1'b0;
    m_to   = 1'b0;
  endtask

  // One microcycle: drive fields, predict, clock, compare
  task automatic step(input string tag, input int op, input int cs, input int cr,
                      input int disp, input int sel, input bit inv, input bit m,
                      input bit cf, input bit irc);
    bit src, t;
    int inc;
    seq_op        = 3'(op);
    current_state = STATE_W'(cs);
    cr_addr       = STATE_W'(cr);
    dispatch_addr = STATE_W'(disp);
    cond_sel      = 2'(sel);
    cond_inv      = inv;
    moc           = m;
    cond_flag     = cf;
    ir_cond       = irc;

    src = (sel == 0) ? m : (sel == 1) ? cf : (sel == 2) ? irc : 1'b1;
    t   = src ^ inv;
    inc = (cs + 1) % NSTATES;
    if (!(op == 4 && !t)) m_held = 0;
    case (op)
      0: m_next = inc;
      1: m_next = cr;
      2: m_next = disp;
      3: m_next = t ? cr : inc;
      4: begin
        if (t) m_next = inc;
        else begin
          m_held++;
          if (m_held == WTO) begin
            m_next = 0; m_to = 1'b1; m_held = 0; m_stack.delete();
          end else m_next = cs;
        end
      end
      5: begin
        m_next = cr;
        if (m_stack.size() == SDEPTH) m_err = 1'b1;
        else m_stack.push_back(inc);
      end
      6: begin
        if (m_stack.size() == 0) begin m_next = 0; m_err = 1'b1; end
        else m_next = m_stack.pop_back();
      end
      default: begin m_next = 0; m_stack.delete(); end
    endcase

    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    seq_op = '0; current_state = '0; cr_addr = '0; dispatch_addr = '0;
    cond_sel = '0; cond_inv = 1'b0; moc = 1'b0; cond_flag = 1'b0; ir_cond = 1'b0;
    model_reset();
    #12;
    chk_all("por");
    reset = 1'b0;

    // Dirty the state, then reset asynchronously between edges
    step("pre_call", 5, 3, 300, 0, 3, 0, 0, 0, 0);
    step("pre_ret1", 6, 300, 0, 0, 3, 0, 0, 0, 0);
    step("pre_ret2", 6, 4, 0, 0, 3, 0, 0, 0, 0);
    step("pre_call2", 5, 9, 500, 0, 3, 0, 0, 0, 0);
    async_reset_check("async_rst");

    // Increment and wrap
    step("inc1", 0, 1, 0, 0, 3, 0, 0, 0, 0);
    step("inc_wrap", 0, 1023, 0, 0, 3, 0, 0, 0, 0);

    // Branch / dispatch
    step("br_taken", 3, 5, 20, 0, 1, 0, 0, 1, 0);
    step("br_inv", 3, 5, 20, 0, 1, 1, 0, 1, 0);
    step("dispatch", 2, 5, 0, 87, 0, 0, 0, 0, 0);
    step("br_ir", 3, 30, 44, 0, 2, 0, 0, 0, 1);

    // WAIT on moc, released before the watchdog
    for (int i = 0; i < 3; i++) step("wait_hold", 4, 25, 0, 0, 0, 0, 0, 0, 0);
    step("wait_done", 4, 25, 0, 0, 0, 0, 1, 0, 0);

    // Watchdog expiry
    for (int i = 0; i < 3; i++) step("wd_hold", 4, 40, 0, 0, 0, 0, 0, 0, 0);
    step("wd_fire", 4, 40, 0, 0, 0, 0, 0, 0, 0);
    step("wd_after", 0, 7, 0, 0, 3, 0, 0, 0, 0);

    // Call / return nesting
    step("call1", 5, 10, 100, 0, 3, 0, 0, 0, 0);
    step("call2", 5, 101, 200, 0, 3, 0, 0, 0, 0);
    step("ret1", 6, 200, 0, 0, 3, 0, 0, 0, 0);
    step("ret2", 6, 102, 0, 0, 3, 0, 0, 0, 0);

    // Overflow and underflow
    for (int i = 0; i < 5; i++) step("ovf_call", 5, 600 + i, 700 + i, 0, 3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("unf_ret", 6, 900, 0, 0, 3, 0, 0, 0, 0);
    async_reset_check("rst_clear_err");

    // Randomized traffic, with WAIT biased toward held cycles
    for (int n = 0; n < 400; n++) begin
      int op, sel;
      bit inv;
      op  = $urandom_range(0, 7);
      sel = $urandom_range(0, 3);
      inv = 1'($urandom_range(0, 1));
      if (op == 4 && $urandom_range(0, 3) != 0) begin sel = 0; inv = 1'b0; end
      step("rand", op, $urandom_range(0, NSTATES - 1), $urandom_range(0, NSTATES - 1),
           $urandom_range(0, NSTATES - 1), sel, inv,
           ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (n == 200) async_reset_check("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
